// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier.
// Results are registered into the EX/MEM pipeline register.
module ex_stage #(
  parameter int D_WIDTH = 32,
  parameter int N_REGS  = 32,
  parameter int RF_SIZE = $clog2(N_REGS),
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush,
  input  logic [D_WIDTH-1:0] rs1_val_ex,
  input  logic [D_WIDTH-1:0] rs2_val_ex,
  input  logic [D_WIDTH-1:0] imm_ex,
  input  logic [RF_SIZE-1:0] rd_ex,
  input  logic               reg_write_ex,
  input  logic               alu_src_imm_ex,
  input  logic               mem_we_ex,
  input  logic               mem_re_ex,
  input  logic [OP_SIZE-1:0] alu_op_ex,
  output logic [D_WIDTH-1:0] alu_result_mem,
  output logic [D_WIDTH-1:0] store_data_mem,
  output logic [RF_SIZE-1:0] rd_mem,
  output logic               reg_write_mem,
  output logic               mem_we_mem,
  output logic               mem_re_mem,
  output logic               ex_busy
);

  localparam int SH_W = $clog2(D_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_SUB  = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_AND  = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_OR   = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_SLL  = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] OP_SRL  = OP_SIZE'(6);
  localparam logic [OP_SIZE-1:0] OP_SRA  = OP_SIZE'(7);
  localparam logic [OP_SIZE-1:0] OP_SLT  = OP_SIZE'(8);
  localparam logic [OP_SIZE-1:0] OP_SLTU = OP_SIZE'(9);
  localparam logic [OP_SIZE-1:0] OP_MUL  = OP_SIZE'(10);

  logic [1:0]         state_q, state_d;
  logic [D_WIDTH-1:0] mcand_q, mcand_d;
  logic [D_WIDTH-1:0] mplier_q, mplier_d;
  logic [D_WIDTH-1:0] acc_q, acc_d;
  logic [SH_W-1:0]    cnt_q, cnt_d;
  logic [D_WIDTH-1:0] res_q, res_d;
  logic [D_WIDTH-1:0] sd_q, sd_d;
  logic [RF_SIZE-1:0] rd_q, rd_d;
  logic               rw_q, rw_d;
  logic               we_q, we_d;
  logic               re_q, re_d;
  logic               busy;

  logic [D_WIDTH-1:0] op_b;
  logic [SH_W-1:0]    shamt;
  logic [D_WIDTH-1:0] alu_res;
  logic               is_mul;

  always_comb begin
    op_b    = alu_src_imm_ex ? imm_ex : rs2_val_ex;
    shamt   = op_b[SH_W-1:0];
    is_mul  = (alu_op_ex == OP_MUL);
    alu_res = '0;
    case (alu_op_ex)
      OP_ADD:  alu_res = rs1_val_ex + op_b;
      OP_SUB:  alu_res = rs1_val_ex - op_b;
      OP_AND:  alu_res = rs1_val_ex & op_b;
      OP_OR:   alu_res = rs1_val_ex | op_b;
      OP_XOR:  alu_res = rs1_val_ex ^ op_b;
      OP_SLL:  alu_res = rs1_val_ex << shamt;
      OP_SRL:  alu_res = rs1_val_ex >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(rs1_val_ex) >>> shamt);
      OP_SLT:  alu_res = {{(D_WIDTH-1){1'b0}},
                          ($signed(rs1_val_ex) < $signed(op_b))};
      OP_SLTU: alu_res = {{(D_WIDTH-1){1'b0}}, (rs1_val_ex < op_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    sd_d     = sd_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    we_d     = we_q;
    re_d     = re_q;
    busy     = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
      res_d   = '0;
      sd_d    = '0;
      rd_d    = '0;
      rw_d    = 1'b0;
      we_d    = 1'b0;
      re_d    = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (en && is_mul) begin
            busy     = 1'b1;
            state_d  = S_RUN;
            mcand_d  = rs1_val_ex;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            res_d    = '0;
            sd_d     = '0;
            rd_d     = '0;
            rw_d     = 1'b0;
            we_d     = 1'b0;
            re_d     = 1'b0;
          end else if (en) begin
            res_d = alu_res;
            sd_d  = rs2_val_ex;
            rd_d  = rd_ex;
            rw_d  = reg_write_ex;
            we_d  = mem_we_ex;
            re_d  = mem_re_ex;
          end
        end
        (state_q == S_RUN): begin
          busy = 1'b1;
          if (en) begin
            res_d = '0;
            sd_d  = '0;
            rd_d  = '0;
            rw_d  = 1'b0;
            we_d  = 1'b0;
            re_d  = 1'b0;
          end
          // One shift-add step per cycle, independent of downstream stalls
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SH_W'(1);
          if (cnt_q == SH_W'(D_WIDTH-1)) state_d = S_DONE;
        end
        (state_q == S_DONE): begin
          if (en) begin
            state_d = S_IDLE;
            res_d   = acc_q;
            sd_d    = rs2_val_ex;
            rd_d    = rd_ex;
            rw_d    = reg_write_ex;
            we_d    = mem_we_ex;
            re_d    = mem_re_ex;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ex_busy = rst_n & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      sd_q     <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      sd_q     <= sd_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      we_q     <= we_d;
      re_q     <= re_d;
    end
  end

  assign alu_result_mem = res_q;
  assign store_data_mem = sd_q;
  assign rd_mem         = rd_q;
  assign reg_write_mem  = rw_q;
  assign mem_we_mem     = we_q;
  assign mem_re_mem     = re_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a transaction-level model.
// Expected EX/MEM contents are tracked in e_* and compared after each edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [31:0] rs1_val_ex;
  logic [31:0] rs2_val_ex;
  logic [31:0] imm_ex;
  logic [4:0]  rd_ex;
  logic        reg_write_ex;
  logic        alu_src_imm_ex;
  logic        mem_we_ex;
  logic        mem_re_ex;
  logic [3:0]  alu_op_ex;
  logic [31:0] alu_result_mem;
  logic [31:0] store_data_mem;
  logic [4:0]  rd_mem;
  logic        reg_write_mem;
  logic        mem_we_mem;
  logic        mem_re_mem;
  logic        ex_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] e_res, e_sd;
  logic [4:0]  e_rd;
  logic        e_rw, e_we, e_re;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .rs1_val_ex(rs1_val_ex), .rs2_val_ex(rs2_val_ex),
    .imm_ex(imm_ex), .rd_ex(rd_ex),
    .reg_write_ex(reg_write_ex), .alu_src_imm_ex(alu_src_imm_ex),
    .mem_we_ex(mem_we_ex), .mem_re_ex(mem_re_ex),
    .alu_op_ex(alu_op_ex),
    .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem),
    .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .mem_we_mem(mem_we_mem), .mem_re_mem(mem_re_mem),
    .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    logic [63:0] p;
    sh = int'(b % 32);
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return 32'(int'(a) >>> sh);
      8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_bubble();
    e_res = 0; e_sd = 0; e_rd = 0;
    e_rw = 0; e_we = 0; e_re = 0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "/res"}, alu_result_mem, e_res);
    chk({tag, "/sd"},  store_data_mem, e_sd);
    chk({tag, "/rd"},  32'(rd_mem), 32'(e_rd));
    chk({tag, "/rw"},  32'(reg_write_mem), 32'(e_rw));
    chk({tag, "/we"},  32'(mem_we_mem), 32'(e_we));
    chk({tag, "/re"},  32'(mem_re_mem), 32'(e_re));
  endtask

  task automatic drive(input int op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic src, input logic [4:0] rd,
                       input logic rw, input logic we, input logic re);
    alu_op_ex      = 4'(op);
    rs1_val_ex     = a;
    rs2_val_ex     = b;
    imm_ex         = imm;
    alu_src_imm_ex = src;
    rd_ex          = rd;
    reg_write_ex   = rw;
    mem_we_ex      = we;
    mem_re_ex      = re;
  endtask

  task automatic do_alu(input string tag, input int op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic src,
                        input logic [4:0] rd, input logic rw,
                        input logic we, input logic re);
    drive(op, a, b, imm, src, rd, rw, we, re);
    en = 1; flush = 0;
    #1;
    chk({tag, "/busy"}, 32'(ex_busy), 32'd0);
    @(posedge clk); #1;
    e_res = ref_alu(op, a, src ? imm : b);
    e_sd = b; e_rd = rd; e_rw = rw; e_we = we; e_re = re;
    check_out(tag);
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm,
                        input logic src, input logic [4:0] rd,
                        input logic rw, input int hold);
    int busy_cyc, edges, bad;
    drive(10, a, b, imm, src, rd, rw, 1'b0, 1'b0);
    en = 1; flush = 0;
    #1;
    busy_cyc = 0; edges = 0; bad = 0;
    while (ex_busy && edges < 40) begin
      busy_cyc++;
      @(posedge clk); #1;
      edges++;
      if (alu_result_mem !== 0 || store_data_mem !== 0 || rd_mem !== 0 ||
          reg_write_mem !== 0 || mem_we_mem !== 0 || mem_re_mem !== 0)
        bad++;
    end
    chk({tag, "/busy_cycles"}, busy_cyc, 33);
    chk({tag, "/edges"}, edges, 33);
    chk({tag, "/bubbles"}, bad, 0);
    model_bubble();
    en = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "/done_busy"}, 32'(ex_busy), 32'd0);
      check_out({tag, "/done_hold"});
    end
    en = 1;
    @(posedge clk); #1;
    e_res = ref_alu(10, a, src ? imm : b);
    e_sd = b; e_rd = rd; e_rw = rw; e_we = 0; e_re = 0;
    check_out(tag);
  endtask

  task automatic hold_cycles(input int n);
    en = 0; flush = 0;
    drive(int'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
          1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom));
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("hold/busy", 32'(ex_busy), 32'd0);
      check_out("hold");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 40);
      1: return 32'hFFFF_FFFF - $urandom_range(0, 3);
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 0; en = 1; flush = 0;
    drive(10, 7, 6, 0, 0, 1, 1, 0, 0);
    model_bubble();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset");
    chk("reset/busy", 32'(ex_busy), 32'd0);
    alu_op_ex = 0;
    rst_n = 1;

    do_alu("add_imm", 0, 5, 0, 32'hFFFF_FFFF, 1, 3, 1, 0, 0);
    chk("add_imm/val", alu_result_mem, 32'd4);
    do_alu("sub_wrap", 1, 0, 1, 0, 0, 4, 1, 0, 0);
    chk("sub_wrap/val", alu_result_mem, 32'hFFFF_FFFF);
    do_alu("sra", 7, 32'h8000_0000, 0, 4, 1, 5, 1, 0, 0);
    chk("sra/val", alu_result_mem, 32'hF800_0000);
    do_alu("sltu", 9, 1, 32'hFFFF_FFFF, 0, 0, 6, 1, 0, 0);
    chk("sltu/val", alu_result_mem, 32'd1);
    do_alu("slt", 8, 1, 32'hFFFF_FFFF, 0, 0, 7, 1, 0, 0);
    chk("slt/val", alu_result_mem, 32'd0);
    do_alu("store", 0, 32'h100, 32'hDEAD, 8, 1, 0, 0, 1, 0);
    chk("store/val", alu_result_mem, 32'h108);
    do_alu("add_hold", 0, 10, 20, 0, 0, 2, 1, 0, 1);
    hold_cycles(3);

    do_mul("mul7x6", 7, 6, 0, 0, 9, 1, 0);
    chk("mul7x6/val", alu_result_mem, 32'd42);
    do_mul("mul_neg", 32'hFFFF_FFFF, 2, 0, 0, 11, 1, 2);
    chk("mul_neg/val", alu_result_mem, 32'hFFFF_FFFE);
    do_alu("after_mul", 4, 32'hF0F0, 32'h0FF0, 0, 0, 12, 1, 0, 0);
    do_mul("b2b_a", 123, 456, 0, 0, 13, 1, 0);
    do_mul("b2b_b", 32'h1234_5678, 0, 32'h9ABC_DEF1, 1, 14, 1, 1);

    drive(10, 3, 5, 0, 0, 15, 1, 0, 0);
    en = 1; flush = 0;
    #1;
    repeat (11) @(posedge clk);
    #1;
    chk("flush/pre_busy", 32'(ex_busy), 32'd1);
    flush = 1;
    #1;
    chk("flush/busy", 32'(ex_busy), 32'd0);
    @(posedge clk); #1;
    flush = 0;
    model_bubble();
    check_out("flush");
    do_mul("post_flush", 11, 13, 0, 0, 16, 1, 0);
    chk("post_flush/val", alu_result_mem, 32'd143);

    do_alu("pre_rst", 0, 1, 2, 0, 0, 17, 1, 0, 0);
    #2 rst_n = 0;
    #1;
    model_bubble();
    check_out("async_rst");
    rst_n = 1;
    @(posedge clk); #1;

    drive(10, 9, 9, 0, 0, 18, 1, 0, 0);
    en = 1;
    #1;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check_out("rst_mid");
    chk("rst_mid/busy", 32'(ex_busy), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid/busy2", 32'(ex_busy), 32'd0);
    alu_op_ex = 0;
    rst_n = 1;
    do_alu("post_rst", 0, 100, 23, 0, 0, 19, 1, 0, 0);
    chk("post_rst/val", alu_result_mem, 32'd123);

    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 15));
      if (op == 10)
        do_mul("rnd_mul", pick(), pick(), pick(), 1'($urandom),
               5'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      else
        do_alu("rnd_alu", op, pick(), pick(), pick(), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) hold_cycles(2);
    end
    for (int it = 0; it < 3; it++)
      do_mul("rnd_mul_f", pick(), pick(), 0, 0, 5'($urandom), 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; consumes the ID/EX pipeline register produced by the decode stage.
- Performs single-cycle ALU operations, plus a multi-cycle shift-add multiply under an FSM.
- Registers results into the EX/MEM pipeline register feeding the memory stage.
- Raises ex_busy so that decode freezes the ID/EX register while a multiply is in flight.

Parameters:
- D_WIDTH, 32: datapath width.
- N_REGS, 32: register file entries.
- RF_SIZE, $clog2(N_REGS): register index width.
- OP_SIZE, 4: ALU opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  downstream advance; 0 freezes the EX/MEM register and holds the FSM in IDLE/DONE.
- flush  in  1  synchronous squash of the current EX contents.
- rs1_val_ex  in  D_WIDTH  operand A.
- rs2_val_ex  in  D_WIDTH  register operand B, also store data.
- imm_ex  in  D_WIDTH  immediate.
- rd_ex  in  RF_SIZE  destination register.
- reg_write_ex, alu_src_imm_ex, mem_we_ex, mem_re_ex  in  1 each  control bits from decode.
- alu_op_ex  in  OP_SIZE  ALU operation.
- alu_result_mem  out  D_WIDTH  registered result.
- store_data_mem  out  D_WIDTH  registered rs2_val_ex.
- rd_mem  out  RF_SIZE  registered destination.
- reg_write_mem, mem_we_mem, mem_re_mem  out  1 each  registered controls.
- ex_busy  out  1  combinational; decode must hold its inputs stable while high.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All *_mem outputs go to 0 and the FSM goes to IDLE.
  - ex_busy=0 while in reset.
  - A reset during RUN aborts the multiply; no partial result is ever written.
- Operand B = alu_src_imm_ex ? imm_ex : rs2_val_ex. Shift amount = B[$clog2(D_WIDTH)-1:0].
- alu_op encoding (all arithmetic is modulo 2^D_WIDTH):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed, result 0/1), 1001 SLTU (unsigned, result 0/1).
  - 1010 MUL (low D_WIDTH bits of the product, signedness irrelevant).
  - 1011-1111: result 0, controls pass through unchanged.
- Bubble = EX/MEM loaded with reg_write_mem=0, mem_we_mem=0, mem_re_mem=0, data fields 0.
- Non-MUL op: when en=1 and flush=0, EX/MEM loads the ALU result and controls on the next edge (latency 1).
- en=0: all EX/MEM outputs hold. flush has priority over en.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - If en=1 and alu_op_ex=MUL and flush=0: ex_busy=1 combinationally.
    - On that edge: EX/MEM loads a bubble, latch A into multiplicand, latch B into multiplier, acc=0, cnt=0, go to RUN.
  - RUN:
    - ex_busy=1; EX/MEM loads a bubble each cycle while en=1.
    - Each cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++.
    - cnt counts 0..D_WIDTH-1; after D_WIDTH RUN cycles go to DONE.
    - RUN iterates regardless of en.
  - DONE:
    - ex_busy=0.
    - When en=1: EX/MEM loads acc and the current (held) rd/controls/store data, then go to IDLE.
    - When en=0: stay in DONE.
- MUL occupancy: 1 accept cycle + D_WIDTH RUN cycles + 1 DONE cycle = D_WIDTH+2 cycles with en held high. Decode advances on the DONE edge.
- flush:
  - In any state: FSM goes to IDLE and EX/MEM loads a bubble on that edge.
  - ex_busy is 0 in the flush cycle.
- An ALU op after a MUL is accepted the cycle after DONE, with no extra gap.
- Back-to-back MULs: the second one starts from IDLE the cycle after DONE.

Test Plan:
- ADD, B=imm: rs1=5, imm=0xFFFFFFFF, alu_src_imm=1, rd=3, reg_write=1 -> next edge alu_result_mem=4, rd_mem=3, reg_write_mem=1.
- SUB wrap, SRA, SLTU: 0-1 -> 0xFFFFFFFF; SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT 1 vs 0xFFFFFFFF -> 0.
- MUL 7x6, rd=9:
  - ex_busy high for exactly 33 cycles with bubbles on the EX/MEM outputs.
  - Then alu_result_mem=42, reg_write_mem=1, rd_mem=9, D_WIDTH+2 edges after issue.
  - MUL 0xFFFFFFFF x 2 -> 0xFFFFFFFE.
- Store pass-through: mem_we=1, rs1=0x100, imm=8, rs2=0xDEAD -> alu_result_mem=0x108, store_data_mem=0xDEAD, mem_we_mem=1.
- Hold/flush:
  - en=0 for 3 cycles after an ADD -> outputs constant.
  - flush at RUN cycle 10 -> ex_busy=0, bubble on EX/MEM, next MUL computes correctly.
- Reset mid-MUL: rst_n low at RUN cycle 5 -> all outputs 0 immediately; after release, an ADD completes with latency 1.
